wb_slave_mem: RTL and testbench
===============================

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 32, sets the Wishbone address width in bits.
REQ-002 Parameter WB_DATA_WIDTH, default 16, sets the Wishbone data width in bits; two byte lanes.
REQ-003 Parameter MEM_DEPTH_LOG2, default 4, sets the memory depth to 2**MEM_DEPTH_LOG2 words.
REQ-004 Parameter WAIT_STATES, default 2 (range 0..15), sets the cycles inserted between strobe detection and the ack cycle.
REQ-005 hclk  input  1  Single clock; all state changes on its rising edge.
REQ-006 hresetn  input  1  Reset; asynchronous, active-low.
REQ-007 cyc_i  input  1  Wishbone cycle valid.
REQ-008 stb_i  input  1  Wishbone strobe.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 adr_i  input  WB_ADDR_WIDTH  Byte address from the upstream ahb2wb bridge.
REQ-011 dat_i  input  WB_DATA_WIDTH  Write data.
REQ-012 sel_i  input  2  Byte-lane enables; bit0 = dat[7:0], bit1 = dat[15:8].
REQ-013 dat_o  output  WB_DATA_WIDTH  Read data, valid while ack_o is high.
REQ-014 ack_o  output  1  Normal termination; registered.
REQ-015 err_o  output  1  Error termination; registered; tied 0 when WB_SLAVE_MEM_ERR_EN is undefined.

Function
REQ-016 The block shall be a Wishbone classic slave placed directly downstream of the ahb2wb bridge, with FSM states IDLE, WAIT, ACK.
REQ-017 Word index shall be adr_i[MEM_DEPTH_LOG2:1]; adr_i[0] is ignored.
REQ-018 An access is in range when adr_i[WB_ADDR_WIDTH-1:MEM_DEPTH_LOG2+1] is all zero, and out of range otherwise.
REQ-019 IDLE transitions:
- cyc_i&stb_i sampled high -> latch we_i/adr_i/dat_i/sel_i and load a counter with WAIT_STATES.
- Counter 0 -> go to ACK.
- Counter non-zero -> go to WAIT.
REQ-020 WAIT shall decrement the counter each cycle and go to ACK on the cycle it reaches 0, so the termination signal rises WAIT_STATES+1 cycles after the first strobe-sampling edge.
REQ-021 ACK shall assert exactly one of ack_o/err_o for exactly one cycle, then return to IDLE; back-to-back strobes are re-sampled in IDLE, giving at least one idle cycle between terminations.
REQ-022 Writes shall commit at the ACK-entry edge, only to in-range words, and only on lanes with sel_i bit set; sel_i=0 acks with no change.
REQ-023 Reads shall drive dat_o with the latched word during ACK (all lanes, regardless of sel_i); dat_o shall be 0 outside ACK.
REQ-024 If cyc_i drops in WAIT (abort), the FSM shall return to IDLE next edge with no write, no ack_o and no err_o.
REQ-025 Input changes during WAIT shall be ignored; latched values govern the access.

Reset
REQ-026 hresetn low shall asynchronously force the state to IDLE, the counter, ack_o, err_o and dat_o to 0, and all memory words to 0.
REQ-027 Reset asserted mid-access shall discard the access; the first post-reset access starts from IDLE.

Configuration
REQ-028 Macro WB_SLAVE_MEM_ERR_EN defined: out-of-range accesses terminate with err_o (ack_o low), writes are dropped, and dat_o=0.
REQ-029 Macro WB_SLAVE_MEM_ERR_EN undefined: out-of-range accesses terminate with ack_o, writes are dropped, read data is 0, and err_o is constant 0.

Verification
REQ-030 WAIT_STATES=2: write 0xA5C3 to adr 0x0000_0006, then read it back -> ack_o rises 3 cycles after strobe for each access, and dat_o=0xA5C3 on the read ack.
REQ-031 With word 0x0002=0xFFFF, write 0x1234 with sel_i=2'b01 -> readback 0xFF34.
REQ-032 Access to adr 0x0000_0100 (out of range, depth 16) -> with WB_SLAVE_MEM_ERR_EN, err_o pulses one cycle; without it, ack_o pulses and read data is 0x0000.
REQ-033 Write started, cyc_i dropped one cycle into WAIT -> no ack_o/err_o, and the target word is unchanged on readback.
REQ-034 Assert hresetn low in WAIT, then release -> outputs 0, memory reads 0x0000, and the next access completes with normal latency.
REQ-035 WAIT_STATES=0 with back-to-back reads -> ack_o is high one cycle after strobe sampling, with one idle cycle between acks.

Source files
------------

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave with a small byte-lane-writable memory and programmable wait states.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wb_slave_mem #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int MEM_DEPTH_LOG2 = 4,
  parameter int WAIT_STATES    = 2
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic [1:0]               sel_i,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     ack_o,
  output logic                     err_o
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

`ifdef WB_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [1:0]                 sel_q, sel_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic [WB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [WB_DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [WB_DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                       cur_we;
  logic [WB_ADDR_WIDTH-1:0]   cur_adr;
  logic [WB_DATA_WIDTH-1:0]   cur_dat;
  logic [1:0]                 cur_sel;
  logic                       in_range;
  logic [MEM_DEPTH_LOG2-1:0]  word_idx;
  logic                       acc_go;
  logic                       unused_adr_bit;

  // With zero wait states the access completes straight out of IDLE, before the latches are loaded.
  always_comb begin
    cur_we  = we_q;
    cur_adr = adr_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    if (state_q == IDLE) begin
      cur_we  = we_i;
      cur_adr = adr_i;
      cur_dat = dat_i;
      cur_sel = sel_i;
    end
    in_range = (cur_adr[WB_ADDR_WIDTH-1:MEM_DEPTH_LOG2+1] == '0);
    word_idx = cur_adr[MEM_DEPTH_LOG2:1];
  end

  assign unused_adr_bit = cur_adr[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    mem_d   = mem_q;
    acc_go  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          we_d  = we_i;
          adr_d = adr_i;
          dat_d = dat_i;
          sel_d = sel_i;
          cnt_d = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            acc_go  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ACK;
            acc_go  = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Commit and terminate on the edge that enters ACK, so outputs are registered for the ACK cycle.
    if (acc_go) begin
      err_d = ERR_EN && !in_range;
      ack_d = !(ERR_EN && !in_range);
      if (in_range) begin
        if (cur_we) begin
          if (cur_sel[0]) mem_d[word_idx][7:0]  = cur_dat[7:0];
          if (cur_sel[1]) mem_d[word_idx][15:8] = cur_dat[15:8];
        end else begin
          rdata_d = mem_q[word_idx];
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign dat_o = rdata_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Scoreboard bench for wb_slave_mem: one instance with two wait states, one with none.
// Honours WB_SLAVE_MEM_ERR_EN when deciding how out-of-range accesses should terminate.
module tb_wb_slave_mem;

`ifdef WB_SLAVE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cyc    [2];
  logic        stb    [2];
  logic        we     [2];
  logic [31:0] adr    [2];
  logic [15:0] dat_wr [2];
  logic [1:0]  sel    [2];
  logic [15:0] dat_rd [2];
  logic        ack    [2];
  logic        err    [2];

  int ws_of [2] = '{2, 0};

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [2][16];

  typedef struct {
    string       name;
    int          lat;
    logic        ack;
    logic        err;
    logic        is_read;
    logic [15:0] data;
  } exp_t;

  exp_t sb [$];

  always #5 hclk = ~hclk;

  wb_slave_mem #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16), .MEM_DEPTH_LOG2(4), .WAIT_STATES(2)) u_dut_ws2 (
    .hclk(hclk), .hresetn(hresetn), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .dat_i(dat_wr[0]), .sel_i(sel[0]),
    .dat_o(dat_rd[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  wb_slave_mem #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(16), .MEM_DEPTH_LOG2(4), .WAIT_STATES(0)) u_dut_ws0 (
    .hclk(hclk), .hresetn(hresetn), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .dat_i(dat_wr[1]), .sel_i(sel[1]),
    .dat_o(dat_rd[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clearModel();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        mem_model[p][i] = 16'h0000;
  endtask

  // Drives one access and waits for its termination; extra adds cycles for back-to-back issue.
  task automatic applyStimulus(input int p, input string name, input logic w, input logic [31:0] a,
                               input logic [15:0] d, input logic [1:0] s, input int extra,
                               input bit scramble);
    exp_t e;
    exp_t got;
    int   cycles;
    bit   seen;
    logic in_r;
    int   idx;
    in_r      = (a[31:5] == 27'd0);
    idx       = int'(a[4:1]);
    e.name    = name;
    e.lat     = ws_of[p] + 1 + extra;
    e.is_read = !w;
    e.err     = ERR_EN && !in_r;
    e.ack     = !(ERR_EN && !in_r);
    e.data    = (!w && in_r) ? mem_model[p][idx] : 16'h0000;
    if (w && in_r) begin
      if (s[0]) mem_model[p][idx][7:0]  = d[7:0];
      if (s[1]) mem_model[p][idx][15:8] = d[15:8];
    end
    sb.push_back(e);
    cyc[p]    = 1'b1;
    stb[p]    = 1'b1;
    we[p]     = w;
    adr[p]    = a;
    dat_wr[p] = d;
    sel[p]    = s;
    cycles    = 0;
    seen      = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge hclk);
      #1;
      cycles++;
      if (ack[p] || err[p]) begin
        seen = 1'b1;
      end else if (scramble && cycles == 1) begin
        we[p]     = ~w;
        adr[p]    = a ^ 32'h6;
        dat_wr[p] = ~d;
        sel[p]    = ~s;
      end
    end
    got = sb.pop_front();
    if (!seen) begin
      checkOutput({got.name, ".timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({got.name, ".lat"}, cycles, got.lat);
      checkOutput({got.name, ".ack"}, {31'd0, ack[p]}, {31'd0, got.ack});
      checkOutput({got.name, ".err"}, {31'd0, err[p]}, {31'd0, got.err});
      if (got.is_read)
        checkOutput({got.name, ".data"}, {16'd0, dat_rd[p]}, {16'd0, got.data});
    end
  endtask

  task automatic endAccess(input int p, input string name);
    cyc[p] = 1'b0;
    stb[p] = 1'b0;
    we[p]  = 1'b0;
    @(posedge hclk);
    #1;
    checkOutput({name, ".pulse"}, {30'd0, ack[p], err[p]}, 32'd0);
    checkOutput({name, ".dat_idle"}, {16'd0, dat_rd[p]}, 32'd0);
  endtask

  task automatic access(input int p, input string name, input logic w, input logic [31:0] a,
                        input logic [15:0] d, input logic [1:0] s);
    applyStimulus(p, name, w, a, d, s, 0, 1'b0);
    endAccess(p, name);
  endtask

  task automatic checkResetOutputs(input string name);
    for (int p = 0; p < 2; p++) begin
      checkOutput({name, ".ack"}, {31'd0, ack[p]}, 32'd0);
      checkOutput({name, ".err"}, {31'd0, err[p]}, 32'd0);
      checkOutput({name, ".dat"}, {16'd0, dat_rd[p]}, 32'd0);
    end
  endtask

  initial begin
    int hits;
    for (int p = 0; p < 2; p++) begin
      cyc[p] = 1'b0; stb[p] = 1'b0; we[p] = 1'b0;
      adr[p] = 32'h0; dat_wr[p] = 16'h0; sel[p] = 2'b00;
    end
    clearModel();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    checkResetOutputs("reset");
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    access(0, "wr_a5c3", 1'b1, 32'h0000_0006, 16'hA5C3, 2'b11);
    access(0, "rd_a5c3", 1'b0, 32'h0000_0006, 16'h0000, 2'b11);

    access(0, "wr_ffff", 1'b1, 32'h0000_0004, 16'hFFFF, 2'b11);
    access(0, "wr_lo",   1'b1, 32'h0000_0004, 16'h1234, 2'b01);
    access(0, "rd_ff34", 1'b0, 32'h0000_0004, 16'h0000, 2'b00);
    access(0, "wr_hi",   1'b1, 32'h0000_0004, 16'h5678, 2'b10);
    access(0, "rd_5634", 1'b0, 32'h0000_0004, 16'h0000, 2'b01);
    access(0, "wr_sel0", 1'b1, 32'h0000_0004, 16'hDEAD, 2'b00);
    access(0, "rd_sel0", 1'b0, 32'h0000_0004, 16'h0000, 2'b11);

    access(0, "wr_oor",  1'b1, 32'h0000_0100, 16'hBEEF, 2'b11);
    access(0, "rd_oor",  1'b0, 32'h0000_0100, 16'h0000, 2'b11);
    access(0, "rd_w0",   1'b0, 32'h0000_0000, 16'h0000, 2'b11);
    access(0, "rd_odd",  1'b0, 32'h0000_0007, 16'h0000, 2'b11);
    access(0, "wr_top",  1'b1, 32'h0000_001E, 16'hC0DE, 2'b11);
    access(0, "rd_top",  1'b0, 32'h0000_001E, 16'h0000, 2'b11);

    applyStimulus(0, "wr_scr", 1'b1, 32'h0000_000A, 16'h0F0F, 2'b11, 0, 1'b1);
    endAccess(0, "wr_scr");
    access(0, "rd_scr",  1'b0, 32'h0000_000A, 16'h0000, 2'b11);
    access(0, "rd_scr2", 1'b0, 32'h0000_000C, 16'h0000, 2'b11);

    // Abort: drop cyc one cycle into WAIT; no termination may follow and memory stays put.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h0000_0004; dat_wr[0] = 16'h9999; sel[0] = 2'b11;
    @(posedge hclk);
    #1;
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    hits = 0;
    repeat (6) begin
      @(posedge hclk);
      #1;
      if (ack[0] || err[0]) hits++;
    end
    checkOutput("abort.term", hits, 32'd0);
    access(0, "rd_abort", 1'b0, 32'h0000_0004, 16'h0000, 2'b11);

    // Reset in the middle of a write that is sitting in WAIT.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h0000_0006; dat_wr[0] = 16'h7777; sel[0] = 2'b11;
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    clearModel();
    #2;
    checkResetOutputs("midrst");
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    checkResetOutputs("postrst");
    access(0, "rd_rst6", 1'b0, 32'h0000_0006, 16'h0000, 2'b11);
    access(0, "rd_rst4", 1'b0, 32'h0000_0004, 16'h0000, 2'b11);
    access(0, "wr_rst",  1'b1, 32'h0000_0008, 16'h4242, 2'b11);
    access(0, "rd_rst8", 1'b0, 32'h0000_0008, 16'h0000, 2'b11);

    // Zero wait states, then back-to-back reads with strobe held high between them.
    access(1, "z_wr2", 1'b1, 32'h0000_0002, 16'h1111, 2'b11);
    access(1, "z_wr4", 1'b1, 32'h0000_0004, 16'h2222, 2'b11);
    applyStimulus(1, "z_b2b0", 1'b0, 32'h0000_0002, 16'h0000, 2'b11, 0, 1'b0);
    applyStimulus(1, "z_b2b1", 1'b0, 32'h0000_0004, 16'h0000, 2'b11, 1, 1'b0);
    applyStimulus(1, "z_b2b2", 1'b0, 32'h0000_0100, 16'h0000, 2'b11, 1, 1'b0);
    endAccess(1, "z_b2b2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
